// File: rtl/sdram_dump_pkg.sv
// Shared encodings and widths for the SDRAM-to-UART block dump.
package sdram_dump_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WB_WORD_WIDTH  = 32;

  // Fetch side: idle, or holding a Wishbone classic read open.
  typedef enum logic {
    F_IDLE = 1'b0,
    F_REQ  = 1'b1
  } fetch_state_t;

  // Emit side: idle, or presenting bytes of the current word to the UART.
  typedef enum logic {
    E_IDLE = 1'b0,
    E_SEND = 1'b1
  } emit_state_t;

endpackage

// File: rtl/word_byte_serializer.sv
// Splits one 32-bit word into four bytes on a valid/ready stream.
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready; once valid is high the data stays stable and valid stays
// high until that transfer happens.
module word_byte_serializer
  import sdram_dump_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WB_WORD_WIDTH-1:0] word_data,
  input  logic                     word_valid,
  output logic                     word_ready,
  output logic [7:0]               byte_data,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic                     emit_idle
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  emit_state_t              state, state_next;
  logic [1:0]               byte_idx;
  logic [WB_WORD_WIDTH-1:0] shreg;
  logic                     last_taken;
  logic                     load;
  logic                     advance;

  assign advance    = (state == E_SEND) && byte_ready;
  assign last_taken = advance && (byte_idx == LAST_BYTE);
  // A new word can enter while idle, or back-to-back as the last byte leaves.
  assign word_ready = (state == E_IDLE) || last_taken;
  assign load       = word_valid && word_ready;

  // The presented byte is always a fixed end of the shift register.
  assign byte_data  = BIG_ENDIAN ? shreg[WB_WORD_WIDTH-1 -: 8] : shreg[7:0];
  assign byte_valid = (state == E_SEND);
  assign emit_idle  = (state == E_IDLE);

  // Emit state register.
  always_ff @(posedge clk) begin
    if (reset) state <= E_IDLE;
    else       state <= state_next;
  end

  // Emit next-state: stay sending while words keep arriving back-to-back.
  always_comb begin
    state_next = state;
    case (state)
      E_IDLE: if (word_valid) state_next = E_SEND;
      E_SEND: if (last_taken) state_next = word_valid ? E_SEND : E_IDLE;
      default: state_next = E_IDLE;
    endcase
  end

  // Shifter and byte index: load a word, or shift one byte out per accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      byte_idx <= '0;
    end else if (load) begin
      shreg    <= word_data;
      byte_idx <= '0;
    end else if (advance) begin
      byte_idx <= byte_idx + 2'd1;
      if (BIG_ENDIAN) shreg <= {shreg[WB_WORD_WIDTH-9:0], 8'h00};
      else            shreg <= {8'h00, shreg[WB_WORD_WIDTH-1:8]};
    end
  end

endmodule

// File: rtl/sdram_uart_dump.sv
// Wishbone classic read master streaming a block of SDRAM words to the UART
// byte stream, with a one-word prefetch buffer ahead of the serializer.
module sdram_uart_dump
  import sdram_dump_pkg::*;
#(
  parameter int ADDR_WIDTH     = 25,
  parameter int LEN_WIDTH      = 16,
  parameter bit BIG_ENDIAN     = 1'b0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [LEN_WIDTH-1:0]     word_count,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [ADDR_WIDTH-1:0]    wb_adr_o,
  output logic [WB_WORD_WIDTH-1:0] wb_dat_o,
  output logic                     wb_we_o,
  output logic                     wb_stb_o,
  output logic                     wb_cyc_o,
  input  logic                     wb_ack_i,
  input  logic [WB_WORD_WIDTH-1:0] wb_dat_i,
  output logic [7:0]               uart_data,
  output logic                     uart_valid,
  input  logic                     uart_ready
);

  localparam int                    TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]         T_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  fetch_state_t             fstate, fstate_next;
  logic [LEN_WIDTH-1:0]     remaining;
  logic                     aborted;
  logic [WB_WORD_WIDTH-1:0] buf_data;
  logic                     buf_full;
  logic [TW-1:0]            tcount;
  logic                     ack_take;
  logic                     timeout_hit;
  logic                     word_ready;
  logic                     word_load;
  logic                     emit_idle;
  logic                     finished;

  assign ack_take    = (fstate == F_REQ) && wb_ack_i;
  assign timeout_hit = (fstate == F_REQ) && !wb_ack_i && (tcount == T_LAST);
  assign word_load   = buf_full && word_ready;
  assign finished    = ((remaining == '0) || aborted) && !buf_full
                       && emit_idle && (fstate == F_IDLE);

  assign wb_cyc_o = (fstate == F_REQ);
  assign wb_stb_o = (fstate == F_REQ);
  assign wb_dat_o = '0;
  assign wb_we_o  = 1'b0;

  // Fetch state register.
  always_ff @(posedge clk) begin
    if (reset) fstate <= F_IDLE;
    else       fstate <= fstate_next;
  end

  // Fetch next-state: one read at a time, only into an empty buffer.
  always_comb begin
    fstate_next = fstate;
    case (fstate)
      F_IDLE: if (busy && !aborted && (remaining != '0) && !buf_full)
                fstate_next = F_REQ;
      F_REQ:  if (ack_take || timeout_hit) fstate_next = F_IDLE;
      default: fstate_next = F_IDLE;
    endcase
  end

  // Transfer control: latch request, advance address/count, flag timeout, finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      aborted   <= 1'b0;
      wb_adr_o  <= '0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy      <= 1'b1;
        error     <= 1'b0;
        aborted   <= 1'b0;
        wb_adr_o  <= base_addr;
        remaining <= word_count;
      end else if (busy) begin
        if (ack_take) begin
          wb_adr_o  <= wb_adr_o + ADDR_ONE;
          remaining <= remaining - LEN_ONE;
        end
        if (timeout_hit) begin
          error   <= 1'b1;
          aborted <= 1'b1;
        end
        if (finished) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

  // Prefetch buffer: filled by an acked read, emptied when the shifter loads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_data <= '0;
      buf_full <= 1'b0;
    end else begin
      if (ack_take) buf_data <= wb_dat_i;
      if (ack_take)       buf_full <= 1'b1;
      else if (word_load) buf_full <= 1'b0;
    end
  end

  // Ack-wait counter, restarted whenever no read is open.
  always_ff @(posedge clk) begin
    if (reset || (fstate != F_REQ)) tcount <= '0;
    else                            tcount <= tcount + TW'(1);
  end

  word_byte_serializer #(.BIG_ENDIAN(BIG_ENDIAN)) u_ser (
    .clk        (clk),
    .reset      (reset),
    .word_data  (buf_data),
    .word_valid (buf_full),
    .word_ready (word_ready),
    .byte_data  (uart_data),
    .byte_valid (uart_valid),
    .byte_ready (uart_ready),
    .emit_idle  (emit_idle)
  );

endmodule

// File: tb/tb_sdram_uart_dump.sv
// Bench for sdram_uart_dump: little-endian instance (index 0) and big-endian
// instance (index 1), both with a 16-cycle ack timeout, sharing one SDRAM image.
module tb_sdram_uart_dump;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  start = '0;
  logic [24:0] base_addr [2];
  logic [15:0] word_count [2];
  logic [1:0]  busy, done, error, we, stb, cyc, ack, valid;
  logic [1:0]  ready = 2'b11;
  logic [24:0] adr [2];
  logic [31:0] dat_o [2];
  logic [31:0] dat_i [2];
  logic [7:0]  udata [2];

  logic [31:0] mem [0:255];
  logic [2:0]  mcnt [2];
  logic        never_ack = 1'b0;

  logic [7:0]  exp_q[$];
  logic [24:0] exp_adr_q[$];

  int checks_total = 0;
  int checks_passed = 0;
  int byte_cnt = 0, read_cnt = 0, done_cnt = 0, cyc_cycles = 0;
  int overlap_cnt = 0, stall_cycles = 0;
  logic [1:0] stalled = '0;
  logic [7:0] held [2];

  always #5 clk = ~clk;

  sdram_uart_dump #(.BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(16)) dut_le (
    .clk(clk), .reset(reset), .start(start[0]), .base_addr(base_addr[0]),
    .word_count(word_count[0]), .busy(busy[0]), .done(done[0]), .error(error[0]),
    .wb_adr_o(adr[0]), .wb_dat_o(dat_o[0]), .wb_we_o(we[0]), .wb_stb_o(stb[0]),
    .wb_cyc_o(cyc[0]), .wb_ack_i(ack[0]), .wb_dat_i(dat_i[0]),
    .uart_data(udata[0]), .uart_valid(valid[0]), .uart_ready(ready[0])
  );

  sdram_uart_dump #(.BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(16)) dut_be (
    .clk(clk), .reset(reset), .start(start[1]), .base_addr(base_addr[1]),
    .word_count(word_count[1]), .busy(busy[1]), .done(done[1]), .error(error[1]),
    .wb_adr_o(adr[1]), .wb_dat_o(dat_o[1]), .wb_we_o(we[1]), .wb_stb_o(stb[1]),
    .wb_cyc_o(cyc[1]), .wb_ack_i(ack[1]), .wb_dat_i(dat_i[1]),
    .uart_data(udata[1]), .uart_valid(valid[1]), .uart_ready(ready[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // SDRAM model: ack 5 cycles after stb rises, data from the shared image.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (reset || !stb[g] || ack[g]) begin
        ack[g]  <= 1'b0;
        mcnt[g] <= '0;
      end else if (mcnt[g] == 3'd4) begin
        if (!never_ack) begin
          ack[g]   <= 1'b1;
          dat_i[g] <= mem[adr[g][7:0]];
        end
      end else begin
        mcnt[g] <= mcnt[g] + 3'd1;
      end
    end
  end

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [7:0]  eb;
    logic [24:0] ea;
    for (int g = 0; g < 2; g++) begin
      if (stalled[g]) begin
        check("uart_hold_valid", 32'(valid[g]), 32'd1);
        check("uart_hold_data", 32'(udata[g]), 32'(held[g]));
      end
      stalled[g] = valid[g] && !ready[g];
      held[g]    = udata[g];
      if (stalled[g]) stall_cycles++;
      if (valid[g] && ready[g]) begin
        eb = (exp_q.size() > 0) ? exp_q.pop_front() : ~udata[g];
        check("uart_byte", 32'(udata[g]), 32'(eb));
        byte_cnt++;
      end
      if (stb[g] && ack[g]) begin
        ea = (exp_adr_q.size() > 0) ? exp_adr_q.pop_front() : ~adr[g];
        check("wb_read_adr", 32'(adr[g]), 32'(ea));
        read_cnt++;
      end
      if (cyc[g]) cyc_cycles++;
      if (cyc[g] && valid[g]) overlap_cnt++;
      if (done[g]) done_cnt++;
    end
  end

  task automatic push_transfer(input int g, input logic [24:0] base, input int cnt);
    logic [24:0] a;
    logic [31:0] w;
    int idx;
    for (int i = 0; i < cnt; i++) begin
      a = base + 25'(i);
      exp_adr_q.push_back(a);
      w = mem[a[7:0]];
      for (int b = 0; b < 4; b++) begin
        idx = (g == 1) ? 3 - b : b;
        exp_q.push_back(w[8*idx +: 8]);
      end
    end
  endtask

  // Drives a one-cycle start; returns at posedge+1 after the sampling edge.
  task automatic do_start(input int g, input logic [24:0] base, input logic [15:0] cnt);
    @(posedge clk); #1;
    base_addr[g]  = base;
    word_count[g] = cnt;
    start[g]      = 1'b1;
    @(posedge clk); #1;
    start[g]      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) begin @(posedge clk); #1; end
    check(tag, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic wait_bytes(input string tag, input int target, input int budget);
    int n = 0;
    while (byte_cnt < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(byte_cnt >= target), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, b0, c0, d0, o0, s0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h10] = 32'h44332211;
    mem[8'h11] = 32'h88776655;
    for (int g = 0; g < 2; g++) begin
      base_addr[g]  = '0;
      word_count[g] = '0;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      check("rst_busy", 32'(busy[g]), 32'd0);
      check("rst_done", 32'(done[g]), 32'd0);
      check("rst_error", 32'(error[g]), 32'd0);
      check("rst_cyc_stb", 32'({cyc[g], stb[g]}), 32'd0);
      check("rst_uart", 32'({valid[g], udata[g]}), 32'd0);
      check("rst_adr", 32'(adr[g]), 32'd0);
      check("rst_dat_we", 32'({dat_o[g] != 32'd0, we[g]}), 32'd0);
    end
    reset = 1'b0;

    // Two little-endian words.
    r0 = read_cnt;
    push_transfer(0, 25'h10, 2);
    do_start(0, 25'h10, 16'd2);
    check("t1_busy", 32'(busy[0]), 32'd1);
    wait_done("t1_done", 400);
    check("t1_reads", 32'(read_cnt - r0), 32'd2);
    check("t1_error", 32'(error[0]), 32'd0);
    check("t1_bytes_left", 32'(exp_q.size()), 32'd0);

    // Same words, big-endian instance.
    r0 = read_cnt;
    push_transfer(1, 25'h10, 2);
    do_start(1, 25'h10, 16'd2);
    wait_done("t2_done", 400);
    check("t2_reads", 32'(read_cnt - r0), 32'd2);
    check("t2_bytes_left", 32'(exp_q.size()), 32'd0);

    // Zero-length transfer.
    b0 = byte_cnt; c0 = cyc_cycles;
    do_start(0, 25'h20, 16'd0);
    check("t3_busy_first", 32'({busy[0], done[0]}), 32'b10);
    @(posedge clk); #1;
    check("t3_done_cycle", 32'({busy[0], done[0]}), 32'b01);
    @(posedge clk); #1;
    check("t3_done_once", 32'(done[0]), 32'd0);
    check("t3_no_cyc", 32'(cyc_cycles - c0), 32'd0);
    check("t3_no_bytes", 32'(byte_cnt - b0), 32'd0);

    // Eight words with a 10-cycle UART stall on word 3 byte 2.
    r0 = read_cnt; b0 = byte_cnt; o0 = overlap_cnt; s0 = stall_cycles;
    push_transfer(0, 25'h20, 8);
    do_start(0, 25'h20, 16'd8);
    wait_bytes("t4_reach_stall", b0 + 14, 400);
    check("t4_stall_valid", 32'(valid[0]), 32'd1);
    ready[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    ready[0] = 1'b1;
    wait_done("t4_done", 800);
    check("t4_reads", 32'(read_cnt - r0), 32'd8);
    check("t4_bytes", 32'(byte_cnt - b0), 32'd32);
    check("t4_stall_cycles", 32'(stall_cycles - s0), 32'd10);
    check("t4_prefetch_overlap", 32'(overlap_cnt > o0), 32'd1);
    check("t4_bytes_left", 32'(exp_q.size()), 32'd0);

    // Address wrap at the top of the word space.
    r0 = read_cnt;
    push_transfer(0, 25'h1FFFFFF, 2);
    do_start(0, 25'h1FFFFFF, 16'd2);
    wait_done("tw_done", 400);
    check("tw_reads", 32'(read_cnt - r0), 32'd2);
    check("tw_error", 32'(error[0]), 32'd0);
    check("tw_bytes_left", 32'(exp_q.size()), 32'd0);

    // Slave never acks: timeout after 16 strobe cycles.
    never_ack = 1'b1;
    b0 = byte_cnt; c0 = cyc_cycles; r0 = read_cnt;
    do_start(0, 25'h60, 16'd2);
    wait_done("t5_done", 200);
    check("t5_cyc_cycles", 32'(cyc_cycles - c0), 32'd16);
    check("t5_error", 32'(error[0]), 32'd1);
    check("t5_no_bytes", 32'(byte_cnt - b0), 32'd0);
    check("t5_no_reads", 32'(read_cnt - r0), 32'd0);
    never_ack = 1'b0;
    do_start(0, 25'h60, 16'd0);
    check("t5_error_cleared", 32'(error[0]), 32'd0);
    wait_done("t5_done2", 20);

    // Reset in the middle of a word.
    push_transfer(0, 25'h30, 4);
    b0 = byte_cnt;
    do_start(0, 25'h30, 16'd4);
    wait_bytes("t6_reach_mid", b0 + 2, 400);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t6_busy", 32'(busy[0]), 32'd0);
    check("t6_cyc_stb", 32'({cyc[0], stb[0]}), 32'd0);
    check("t6_uart", 32'({valid[0], udata[0]}), 32'd0);
    check("t6_adr", 32'(adr[0]), 32'd0);
    check("t6_done_error", 32'({done[0], error[0]}), 32'd0);
    exp_q.delete();
    exp_adr_q.delete();
    d0 = done_cnt;
    repeat (5) @(posedge clk);
    #1;
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);

    // Clean run after reset; a second start while busy is ignored.
    r0 = read_cnt; b0 = byte_cnt;
    push_transfer(0, 25'h40, 1);
    do_start(0, 25'h40, 16'd1);
    do_start(0, 25'h50, 16'd3);
    check("t6_still_busy", 32'(busy[0]), 32'd1);
    wait_done("t6_done", 400);
    repeat (20) @(posedge clk);
    #1;
    check("t6_reads", 32'(read_cnt - r0), 32'd1);
    check("t6_bytes", 32'(byte_cnt - b0), 32'd4);
    check("t6_idle", 32'(busy[0]), 32'd0);
    check("t6_bytes_left", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
